kamacore_writeback_unit: RTL and testbench
==========================================

KAMACORE_WRITEBACK_UNIT -- requirements
Module: kamacore_writeback_unit

Interface
REQ-001 SHALL have no module parameters; CPU_WIDTH (32) and REG_ADDR_WIDTH (5) come from kamacore_pkg; RAW = REG_ADDR_WIDTH.
REQ-002 clk  in  1  clock; all state on posedge clk.
REQ-003 rst  in  1  reset: rst, synchronous, active-low; clock clk.
REQ-004 issue_valid  in  1  decode presents an instruction this cycle.
REQ-005 issue_rd / issue_rs1 / issue_rs2  in  RAW each  destination and sources of that instruction.
REQ-006 issue_stall  out  1  instruction must not issue this cycle.
REQ-007 alu_valid  in  1 / alu_ready  out  1 / alu_rd  in  RAW / alu_data  in  CPU_WIDTH  ALU result channel.
REQ-008 mem_valid  in  1 / mem_ready  out  1 / mem_rd  in  RAW / mem_data  in  CPU_WIDTH  load result channel.
REQ-009 destination_we  out  1 / destination_a  out  RAW / destination_data  out  CPU_WIDTH  register-file write port.
REQ-010 idle  out  1  no pending destinations and write stage empty.

Function
REQ-011 SHALL keep a scoreboard of 2**RAW pending bits; bit 0 permanently 0.
REQ-012 Issue fires when issue_valid && !issue_stall; SHALL set pending[issue_rd] next cycle if issue_rd != 0.
REQ-013 issue_stall = issue_valid && (hazard(rs1) || hazard(rs2) || pending[issue_rd]); hazard(r) = r != 0 && pending[r]; register 0 never stalls.
REQ-014 Arbitration fixed priority: mem_ready = 1 outside reset; alu_ready = !mem_valid; a channel handshakes when valid && ready.
REQ-015 Handshaked result SHALL be registered into a one-entry write stage; destination_we/a/data driven exactly 1 cycle after handshake (latency 1), then dropped unless another handshake occurred.
REQ-016 Results with rd == 0 SHALL be accepted but produce destination_we = 0.
REQ-017 pending[destination_a] SHALL clear on the cycle after destination_we is high.
REQ-018 Simultaneous set and clear of the same bit: set wins.
REQ-019 idle = (no pending bit set) && !destination_we.
REQ-020 Back-to-back results SHALL sustain one write per cycle; alu held under mem contention keeps its data stable (producer obligation) and is accepted first free cycle.

Reset
REQ-021 While rst low: all pending bits 0, write stage empty, destination_we 0, destination_a 0, destination_data 0, mem_ready 0, alu_ready 0, issue_stall 0, idle 1.
REQ-022 Reset mid-operation SHALL discard the in-flight write and all reservations; no write emitted in the cycle after rst rises.

Configuration
REQ-023 Macro KAMACORE_WB_FORWARD_EN defined: hazard(r) SHALL exclude r == destination_a while destination_we is high (register file bypasses that write), removing one stall cycle.
REQ-024 Macro undefined: hazard(r) uses pending only; source stalls until the clear cycle of REQ-017.

Structure
REQ-025 CPU_WIDTH, REG_ADDR_WIDTH and a wb_entry_t struct (valid, rd, data) SHALL live in kamacore_pkg.
REQ-026 Scoreboard SHALL be sub-module kamacore_scoreboard (set port, clear port, three combinational lookup ports, any_pending output).

Verification
REQ-027 Reset: rst=0 for 2 cycles with mem_valid=1 -> mem_ready=0, destination_we=0, idle=1.
REQ-028 Issue rd=5, then rs1=5 next cycle -> issue_stall=1; alu result rd=5 data=0xDEADBEEF -> destination_we=1, a=5, data=0xDEADBEEF 1 cycle later; stall drops same cycle with FORWARD_EN, one cycle later without.
REQ-029 alu_valid and mem_valid same cycle, rd=3/4 -> mem written first (a=4), alu_ready=0 that cycle, a=3 written next cycle.
REQ-030 Issue rd=0, rs1=0 -> never stalls; result rd=0 -> destination_we stays 0, idle remains 1.
REQ-031 WAW: rd=7 pending, issue rd=7 -> issue_stall=1 until pending[7] clears.
REQ-032 Reset asserted while write stage holds rd=9 -> no write to 9 after release, pending[9]=0, idle=1.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared widths and the write-stage entry type for the kamacore writeback path.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [CPU_WIDTH-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/kamacore_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, x0 never pending.
module kamacore_scoreboard
  import kamacore_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_a,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_a,
  input  logic [REG_ADDR_WIDTH-1:0] look_a0,
  input  logic [REG_ADDR_WIDTH-1:0] look_a1,
  input  logic [REG_ADDR_WIDTH-1:0] look_a2,
  output logic                      hit0,
  output logic                      hit1,
  output logic                      hit2,
  output logic                      any_pending
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear is applied before set so a same-cycle set on the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_a] = 1'b0;
    if (set_en) pending_d[set_a] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign hit0        = (look_a0 != '0) && pending_q[look_a0];
  assign hit1        = (look_a1 != '0) && pending_q[look_a1];
  assign hit2        = (look_a2 != '0) && pending_q[look_a2];
  assign any_pending = |pending_q;

endmodule

// File: rtl/kamacore_writeback_unit.sv
// Writeback stage: mem/alu result arbitration, one-entry write stage and issue interlock.
// Define KAMACORE_WB_FORWARD_EN to let sources bypass the write currently on the RF port.
module kamacore_writeback_unit
  import kamacore_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  output logic                      issue_stall,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [CPU_WIDTH-1:0]      alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [CPU_WIDTH-1:0]      mem_data,
  output logic                      destination_we,
  output logic [REG_ADDR_WIDTH-1:0] destination_a,
  output logic [CPU_WIDTH-1:0]      destination_data,
  output logic                      idle
);

  wb_entry_t wb_q, wb_d;
  logic      hit_rs1, hit_rs2, hit_rd, any_pending;
  logic      byp_rs1, byp_rs2;
  logic      issue_fire, alu_hs, mem_hs;

  kamacore_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (issue_fire),
    .set_a       (issue_rd),
    .clr_en      (destination_we),
    .clr_a       (destination_a),
    .look_a0     (issue_rs1),
    .look_a1     (issue_rs2),
    .look_a2     (issue_rd),
    .hit0        (hit_rs1),
    .hit1        (hit_rs2),
    .hit2        (hit_rd),
    .any_pending (any_pending)
  );

`ifdef KAMACORE_WB_FORWARD_EN
  // The register file bypasses the write on its port, so that source is already safe.
  always_comb begin
    byp_rs1 = destination_we && (issue_rs1 == destination_a);
    byp_rs2 = destination_we && (issue_rs2 == destination_a);
  end
`else
  always_comb begin
    byp_rs1 = 1'b0;
    byp_rs2 = 1'b0;
  end
`endif

  always_comb begin
    issue_stall = rst && issue_valid &&
                  ((hit_rs1 && !byp_rs1) || (hit_rs2 && !byp_rs2) || hit_rd);
    issue_fire  = rst && issue_valid && !issue_stall;
  end

  // Loads have fixed priority over ALU results.
  always_comb begin
    mem_ready = rst;
    alu_ready = rst && !mem_valid;
    mem_hs    = mem_valid && mem_ready;
    alu_hs    = alu_valid && alu_ready;
  end

  always_comb begin
    wb_d = '0;
    if (mem_hs) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = mem_rd;
      wb_d.data  = mem_data;
    end else if (alu_hs) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = alu_rd;
      wb_d.data  = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  // Results to x0 occupy the stage but never reach the register file.
  always_comb begin
    destination_we   = rst && wb_q.valid && (wb_q.rd != '0);
    destination_a    = rst ? wb_q.rd : '0;
    destination_data = rst ? wb_q.data : '0;
    idle             = !rst || (!any_pending && !destination_we);
  end

endmodule

// File: tb/tb_kamacore_writeback_unit.sv
// Directed self-checking bench for kamacore_writeback_unit.
module tb_kamacore_writeback_unit;
  import kamacore_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] issue_rd, issue_rs1, issue_rs2;
  logic                      issue_stall;
  logic                      alu_valid, alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [CPU_WIDTH-1:0]      alu_data;
  logic                      mem_valid, mem_ready;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic [CPU_WIDTH-1:0]      mem_data;
  logic                      destination_we;
  logic [REG_ADDR_WIDTH-1:0] destination_a;
  logic [CPU_WIDTH-1:0]      destination_data;
  logic                      idle;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

`ifdef KAMACORE_WB_FORWARD_EN
  localparam logic FwdStall = 1'b0;
`else
  localparam logic FwdStall = 1'b1;
`endif

  always #5 clk = ~clk;

  kamacore_writeback_unit dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .issue_stall      (issue_stall),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .destination_we   (destination_we),
    .destination_a    (destination_a),
    .destination_data (destination_data),
    .idle             (idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; new inputs and checks land 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b1; issue_rd = 5'd1; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h0000_00AA;

    // Reset held with a live load and an issue request
    tick(); tick(); settle();
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_we", 32'(destination_we), 32'd0);
    check("rst_a", 32'(destination_a), 32'd0);
    check("rst_data", destination_data, 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_stall", 32'(issue_stall), 32'd0);
    rst = 1'b1; mem_valid = 1'b0; issue_valid = 1'b0;
    tick(); settle();
    check("post_rst_we", 32'(destination_we), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_mem_ready", 32'(mem_ready), 32'd1);

    // RAW on x5 resolved by an ALU result
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd0; issue_rs2 = 5'd0; settle();
    check("raw_issue_first", 32'(issue_stall), 32'd0);
    tick();
    issue_rd = 5'd0; issue_rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; settle();
    check("raw_stall", 32'(issue_stall), 32'd1);
    check("raw_alu_ready", 32'(alu_ready), 32'd1);
    check("raw_idle_busy", 32'(idle), 32'd0);
    check("raw_we_before", 32'(destination_we), 32'd0);
    tick();
    alu_valid = 1'b0; settle();
    check("raw_we", 32'(destination_we), 32'd1);
    check("raw_a", 32'(destination_a), 32'd5);
    check("raw_data", destination_data, 32'hDEAD_BEEF);
    check("raw_stall_wb_cycle", 32'(issue_stall), 32'(FwdStall));
    check("raw_idle_wb_cycle", 32'(idle), 32'd0);
    tick(); settle();
    check("raw_we_drop", 32'(destination_we), 32'd0);
    check("raw_stall_clear", 32'(issue_stall), 32'd0);
    check("raw_idle_after", 32'(idle), 32'd1);
    issue_valid = 1'b0; issue_rs1 = 5'd0;
    tick();

    // Simultaneous results: load first, ALU waits one cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044; settle();
    check("arb_alu_ready", 32'(alu_ready), 32'd0);
    check("arb_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0; settle();
    check("arb_alu_ready_free", 32'(alu_ready), 32'd1);
    check("arb_we_mem", 32'(destination_we), 32'd1);
    check("arb_a_mem", 32'(destination_a), 32'd4);
    check("arb_data_mem", destination_data, 32'h0000_0044);
    tick();
    alu_valid = 1'b0; settle();
    check("arb_we_alu", 32'(destination_we), 32'd1);
    check("arb_a_alu", 32'(destination_a), 32'd3);
    check("arb_data_alu", destination_data, 32'h0000_0033);
    tick(); settle();
    check("arb_we_drop", 32'(destination_we), 32'd0);
    check("arb_idle", 32'(idle), 32'd1);

    // x0 never stalls and never writes
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234; settle();
    check("x0_stall", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0; settle();
    check("x0_we", 32'(destination_we), 32'd0);
    check("x0_idle", 32'(idle), 32'd1);
    tick();

    // WAW on x7
    issue_valid = 1'b1; issue_rd = 5'd7; settle();
    check("waw_first", 32'(issue_stall), 32'd0);
    tick(); settle();
    check("waw_stall", 32'(issue_stall), 32'd1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_0077;
    tick();
    mem_valid = 1'b0; settle();
    check("waw_we", 32'(destination_we), 32'd1);
    check("waw_a", 32'(destination_a), 32'd7);
    check("waw_stall_wb_cycle", 32'(issue_stall), 32'd1);
    tick(); settle();
    check("waw_stall_clear", 32'(issue_stall), 32'd0);
    tick();

    // Reset while the write stage holds x9
    issue_rd = 5'd9; settle();
    check("r9_issue", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0099;
    tick();
    mem_valid = 1'b0; settle();
    check("r9_we_before_rst", 32'(destination_we), 32'd1);
    check("r9_a_before_rst", 32'(destination_a), 32'd9);
    rst = 1'b0;
    tick(); settle();
    check("r9_we_in_rst", 32'(destination_we), 32'd0);
    check("r9_idle_in_rst", 32'(idle), 32'd1);
    rst = 1'b1;
    tick(); settle();
    check("r9_we_after_rst", 32'(destination_we), 32'd0);
    check("r9_a_after_rst", 32'(destination_a), 32'd0);
    check("r9_idle_after_rst", 32'(idle), 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rs1 = 5'd9; issue_rs2 = 5'd7; settle();
    check("r9_pending_cleared", 32'(issue_stall), 32'd0);
    issue_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
